// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin dmem arbiter with lock bursts, access checks and 1-cycle responses
module dmem_arbiter #(
    parameter int XLEN      = 32,
    parameter int FUNCT3_W  = 3,
    parameter int DMEM_W    = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic                p0_lock,
    input  logic [FUNCT3_W-1:0] p0_funct3,
    input  logic [XLEN-1:0]     p0_addr,
    input  logic [XLEN-1:0]     p0_wdata,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [XLEN-1:0]     p0_rdata,
    output logic                p0_err,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic                p1_lock,
    input  logic [FUNCT3_W-1:0] p1_funct3,
    input  logic [XLEN-1:0]     p1_addr,
    input  logic [XLEN-1:0]     p1_wdata,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [XLEN-1:0]     p1_rdata,
    output logic                p1_err,
    output logic                mem_read,
    output logic                mem_write,
    output logic [FUNCT3_W-1:0] funct3,
    output logic [XLEN-1:0]     addr,
    output logic [XLEN-1:0]     write_data,
    input  logic [XLEN-1:0]     read_data
);
    logic                prio_q, prio_d, lock_q, lock_d, lock_port_q, lock_port_d;
    logic [3:0]          burst_q, burst_d, run;
    logic [1:0]          rvalid_q, rvalid_d, err_q, err_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [1:0]          gnt;
    logic                g, any, fav, s_we, s_lock, bad, legal_f3, misal, oor;
    logic [FUNCT3_W-1:0] s_f3;
    logic [XLEN-1:0]     s_addr, s_wdata;

    // grant selection, access checks, dmem drive and next arbitration/response state
    always_comb begin
        fav = lock_q ? lock_port_q : prio_q;
        gnt = 2'b00;
        if (!reset) begin
            if (p0_req && (!p1_req || !fav)) gnt = 2'b01;
            else if (p1_req)                 gnt = 2'b10;
        end
        any     = |gnt;
        g       = gnt[1];
        s_we    = g ? p1_we     : p0_we;
        s_lock  = g ? p1_lock   : p0_lock;
        s_f3    = g ? p1_funct3 : p0_funct3;
        s_addr  = g ? p1_addr   : p0_addr;
        s_wdata = g ? p1_wdata  : p0_wdata;
        legal_f3 = s_we ? (s_f3 <= FUNCT3_W'(2))
                        : (s_f3 <= FUNCT3_W'(2) || s_f3 == FUNCT3_W'(4) || s_f3 == FUNCT3_W'(5));
        misal = (s_f3[1:0] == 2'd1 && s_addr[0]) || (s_f3[1:0] == 2'd2 && s_addr[1:0] != 2'd0);
        oor   = {2'b00, s_addr[XLEN-1:2]} >= XLEN'(DMEM_W);
        bad   = !legal_f3 || misal || oor;
        mem_read   = any && !bad && !s_we;
        mem_write  = any && !bad && s_we;
        funct3     = any ? s_f3 : '0;
        addr       = any ? s_addr : '0;
        write_data = any ? s_wdata : '0;
        run = (lock_q && lock_port_q == g) ? burst_q + 4'd1 : 4'd1;
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        burst_d     = burst_q;
        if (any) begin
            prio_d = !g;
            if (s_lock && run < 4'(MAX_BURST)) begin
                lock_d      = 1'b1;
                lock_port_d = g;
                burst_d     = run;
            end else begin
                lock_d  = 1'b0;
                burst_d = '0;
            end
        end else if (lock_q && !(lock_port_q ? p1_req : p0_req)) begin
            lock_d  = 1'b0;
            burst_d = '0;
            prio_d  = !lock_port_q;
        end
        rvalid_d = gnt;
        err_d    = gnt & {2{bad}};
        rdata_d  = mem_read ? read_data : '0;
    end

    // state and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q      <= 1'b0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            burst_q     <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            burst_q     <= burst_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // responses are suppressed while reset is held so an in-flight one never escapes
    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid_q[0] && !reset;
    assign p1_rvalid = rvalid_q[1] && !reset;
    assign p0_err    = err_q[0] && !reset;
    assign p1_err    = err_q[1] && !reset;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dmem_arbiter;
    localparam int DW = 64;
    localparam int MB = 4;
    logic        clk = 0, reset = 1;
    logic        p0_req = 0, p0_we = 0, p0_lock = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
    logic [2:0]  p0_funct3 = 0, p1_funct3 = 0, funct3;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_read, mem_write;
    logic [31:0] p0_rdata, p1_rdata, addr, write_data, read_data;
    logic [31:0] mem [DW];
    logic [31:0] mw;
    logic [7:0]  mb;
    logic [15:0] mh;
    logic        mem_clr = 0;
    int          checks = 0, failures = 0;
    logic [7:0]  ref_mem [256];

    dmem_arbiter #(.XLEN(32), .FUNCT3_W(3), .DMEM_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_funct3(p0_funct3),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_funct3(p1_funct3),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // dmem environment: sized stores on the clock, sized/sign-extended combinational loads
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < DW; i++) mem[i] <= 0;
        else if (mem_write) begin
            if (funct3 == 0)      mem[addr[7:2]][8*addr[1:0] +: 8]  <= write_data[7:0];
            else if (funct3 == 1) mem[addr[7:2]][16*addr[1] +: 16] <= write_data[15:0];
            else                  mem[addr[7:2]]                   <= write_data;
        end
    end

    always_comb begin
        mw = mem[addr[7:2]];
        mb = mw[8*addr[1:0] +: 8];
        mh = mw[16*addr[1] +: 16];
        case (funct3)
            3'd0:    read_data = {{24{mb[7]}}, mb};
            3'd1:    read_data = {{16{mh[15]}}, mh};
            3'd2:    read_data = mw;
            3'd4:    read_data = {24'b0, mb};
            3'd5:    read_data = {16'b0, mh};
            default: read_data = 0;
        endcase
    end

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int p, bit r, bit we, bit lk, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_lock = lk; p0_funct3 = f3; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_we = we; p1_lock = lk; p1_funct3 = f3; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic do_reset(bit clr);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        reset = 1;
        mem_clr = clr;
        clk_step;
        clk_step;
        mem_clr = 0;
        reset = 0;
    endtask

    function automatic int sz(int f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic bit legal(bit we, int f3, int a);
        bit f3_ok = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        return f3_ok && (a % sz(f3) == 0) && (a / 4 < DW);
    endfunction

    function automatic logic [31:0] ld(int f3, int a);
        logic [31:0] v = 0;
        for (int k = 0; k < sz(f3); k++) v = v | (32'(ref_mem[a+k]) << (8*k));
        if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic test_reset;
        reset = 1;
        drv(0, 1, 0, 0, 2, 32'h10, 0);
        drv(1, 1, 1, 0, 2, 32'h20, 1);
        clk_step;
        clk_step;
        #4;
        checks++; if (p0_gnt !== 0)    begin failures++; $display("FAIL rst_p0_gnt got=%0b exp=0", p0_gnt); end
        checks++; if (p1_gnt !== 0)    begin failures++; $display("FAIL rst_p1_gnt got=%0b exp=0", p1_gnt); end
        checks++; if (mem_read !== 0)  begin failures++; $display("FAIL rst_mem_read got=%0b exp=0", mem_read); end
        checks++; if (mem_write !== 0) begin failures++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write); end
        checks++; if (p0_rvalid !== 0 || p1_rvalid !== 0) begin failures++; $display("FAIL rst_rvalid got=%0b%0b exp=00", p1_rvalid, p0_rvalid); end
        checks++; if (p0_err !== 0 || p0_rdata !== 0) begin failures++; $display("FAIL rst_err_rdata got=%0b/%0h exp=0/0", p0_err, p0_rdata); end
        checks++; if (addr !== 0)      begin failures++; $display("FAIL rst_addr got=%0h exp=0", addr); end
        do_reset(0);
    endtask

    task automatic test_round_robin;
        drv(0, 1, 1, 0, 2, 32'h10, 32'h1111_AAAA);
        clk_step;
        drv(0, 1, 1, 0, 2, 32'h20, 32'h2222_BBBB);
        clk_step;
        do_reset(0);
        drv(0, 1, 0, 0, 2, 32'h10, 0);
        drv(1, 1, 0, 0, 2, 32'h20, 0);
        #4;
        checks++; if (p0_gnt !== 1 || p1_gnt !== 0) begin failures++; $display("FAIL rr_c0_gnt got=%0b%0b exp=01", p1_gnt, p0_gnt); end
        checks++; if (mem_read !== 1 || addr !== 32'h10) begin failures++; $display("FAIL rr_c0_mem got=%0b/%0h exp=1/10", mem_read, addr); end
        clk_step;
        drv(0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++; if (p1_gnt !== 1 || addr !== 32'h20) begin failures++; $display("FAIL rr_c1_gnt got=%0b/%0h exp=1/20", p1_gnt, addr); end
        checks++; if (p0_rvalid !== 1 || p0_rdata !== 32'h1111_AAAA || p0_err !== 0) begin failures++; $display("FAIL rr_c1_p0rsp got=%0b/%0h/%0b exp=1/1111aaaa/0", p0_rvalid, p0_rdata, p0_err); end
        clk_step;
        drv(1, 0, 0, 0, 0, 0, 0);
        #4;
        checks++; if (p1_rvalid !== 1 || p1_rdata !== 32'h2222_BBBB) begin failures++; $display("FAIL rr_c2_p1rsp got=%0b/%0h exp=1/2222bbbb", p1_rvalid, p1_rdata); end
        checks++; if (p0_rvalid !== 0) begin failures++; $display("FAIL rr_c2_p0rv got=%0b exp=0", p0_rvalid); end
        clk_step;
    endtask

    task automatic test_lock_burst;
        do_reset(0);
        for (int i = 0; i < MB; i++) begin
            drv(1, 1, 0, 1, 2, 32'h0, 0);
            if (i > 0) drv(0, 1, 0, 0, 2, 32'h4, 0);
            #4;
            checks++; if (p1_gnt !== 1 || p0_gnt !== 0) begin failures++; $display("FAIL lock_burst_%0d got=%0b%0b exp=10", i, p1_gnt, p0_gnt); end
            clk_step;
        end
        #4;
        checks++; if (p0_gnt !== 1 || p1_gnt !== 0) begin failures++; $display("FAIL lock_release got=%0b%0b exp=01", p1_gnt, p0_gnt); end
        clk_step;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        clk_step;
    endtask

    task automatic test_errors;
        do_reset(0);
        drv(0, 1, 0, 0, 1, 32'h3, 0);
        #4;
        checks++; if (p0_gnt !== 1 || mem_read !== 0) begin failures++; $display("FAIL err_lh_grant got=%0b/%0b exp=1/0", p0_gnt, mem_read); end
        clk_step;
        drv(0, 1, 1, 0, 2, 32'(4*DW), 32'h5555_5555);
        #4;
        checks++; if (p0_rvalid !== 1 || p0_err !== 1 || p0_rdata !== 0) begin failures++; $display("FAIL err_lh_rsp got=%0b/%0b/%0h exp=1/1/0", p0_rvalid, p0_err, p0_rdata); end
        checks++; if (p0_gnt !== 1 || mem_write !== 0) begin failures++; $display("FAIL err_oor_grant got=%0b/%0b exp=1/0", p0_gnt, mem_write); end
        clk_step;
        drv(0, 1, 1, 0, 2, 32'h8, 32'hDEAD_BEEF);
        #4;
        checks++; if (p0_err !== 1) begin failures++; $display("FAIL err_oor_rsp got=%0b exp=1", p0_err); end
        checks++; if (mem_write !== 1 || write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_drive got=%0b/%0h exp=1/deadbeef", mem_write, write_data); end
        clk_step;
        drv(0, 1, 0, 0, 2, 32'h8, 0);
        #4;
        checks++; if (p0_err !== 0 || p0_rdata !== 0 || p0_rvalid !== 1) begin failures++; $display("FAIL sw_rsp got=%0b/%0b/%0h exp=1/0/0", p0_rvalid, p0_err, p0_rdata); end
        clk_step;
        drv(0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++; if (p0_rdata !== 32'hDEAD_BEEF || p0_err !== 0) begin failures++; $display("FAIL lw_back got=%0h/%0b exp=deadbeef/0", p0_rdata, p0_err); end
        clk_step;
    endtask

    task automatic test_reset_inflight;
        do_reset(0);
        drv(0, 1, 0, 0, 2, 32'h10, 0);
        #4;
        checks++; if (p0_gnt !== 1) begin failures++; $display("FAIL rif_grant got=%0b exp=1", p0_gnt); end
        clk_step;
        drv(0, 1, 0, 0, 2, 32'h10, 0);
        drv(1, 1, 0, 0, 2, 32'h20, 0);
        reset = 1;
        #4;
        checks++; if (p0_rvalid !== 0) begin failures++; $display("FAIL rif_rvalid got=%0b exp=0", p0_rvalid); end
        checks++; if (p0_gnt !== 0 || p1_gnt !== 0 || mem_read !== 0) begin failures++; $display("FAIL rif_gnt_in_reset got=%0b%0b/%0b exp=00/0", p1_gnt, p0_gnt, mem_read); end
        clk_step;
        reset = 0;
        #4;
        checks++; if (p0_rvalid !== 0) begin failures++; $display("FAIL rif_rvalid_after got=%0b exp=0", p0_rvalid); end
        checks++; if (p0_gnt !== 1 || p1_gnt !== 0) begin failures++; $display("FAIL rif_next_gnt got=%0b%0b exp=01", p1_gnt, p0_gnt); end
        clk_step;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        clk_step;
    endtask

    task automatic test_random;
        bit          pend [2], rwe [2], rlk [2], erv [2], eerr [2], nrv [2], nerr [2], ok;
        int          rf3 [2], ra [2], win, last, owner, run, r;
        logic [31:0] rd [2], erd [2], nrd [2];
        bit          gv [2], rv [2], ev [2];
        logic [31:0] dv [2];
        int          sel;
        do_reset(1);
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
        last = 1; owner = -1; run = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; erv[p] = 0; eerr[p] = 0; erd[p] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 65) begin
                    pend[p] = 1;
                    rwe[p] = $urandom_range(0, 1) == 1;
                    rlk[p] = $urandom_range(0, 1) == 1;
                    sel = $urandom_range(0, 9);
                    rf3[p] = (sel < 8) ? ((sel % 5 < 3) ? sel % 5 : sel % 5 + 1) : $urandom_range(0, 7);
                    sel = $urandom_range(0, 9);
                    ra[p] = (sel < 7) ? ($urandom_range(0, 63) / sz(rf3[p])) * sz(rf3[p])
                          : (sel < 9) ? $urandom_range(0, 255) : $urandom_range(256, 4000);
                    rd[p] = $urandom;
                end
                drv(p, pend[p], rwe[p], rlk[p], 3'(rf3[p]), 32'(ra[p]), rd[p]);
            end
            #4;
            if (pend[0] && pend[1]) win = (owner >= 0) ? owner : (last == 0 ? 1 : 0);
            else win = pend[0] ? 0 : pend[1] ? 1 : -1;
            ok = (win >= 0) && legal(rwe[win], rf3[win], ra[win]);
            gv[0] = p0_gnt; gv[1] = p1_gnt;
            rv[0] = p0_rvalid; rv[1] = p1_rvalid;
            ev[0] = p0_err; ev[1] = p1_err;
            dv[0] = p0_rdata; dv[1] = p1_rdata;
            for (int p = 0; p < 2; p++) begin
                checks++; if (gv[p] !== (win == p)) begin failures++; $display("FAIL rnd_gnt%0d cyc=%0d got=%0b exp=%0b", p, c, gv[p], win == p); end
                checks++; if (rv[p] !== erv[p] || ev[p] !== eerr[p]) begin failures++; $display("FAIL rnd_rsp%0d cyc=%0d got=%0b/%0b exp=%0b/%0b", p, c, rv[p], ev[p], erv[p], eerr[p]); end
                if (erv[p]) begin
                    checks++; if (dv[p] !== erd[p]) begin failures++; $display("FAIL rnd_rdata%0d cyc=%0d got=%0h exp=%0h", p, c, dv[p], erd[p]); end
                end
            end
            checks++; if (mem_read !== (ok && !rwe[win == 1]) || mem_write !== (ok && rwe[win == 1])) begin failures++; $display("FAIL rnd_mem cyc=%0d got=%0b/%0b ok=%0b", c, mem_read, mem_write, ok); end
            for (int p = 0; p < 2; p++) begin
                nrv[p] = 0; nerr[p] = 0; nrd[p] = 0;
            end
            if (win >= 0) begin
                nrv[win] = 1;
                nerr[win] = !ok;
                nrd[win] = (ok && !rwe[win]) ? ld(rf3[win], ra[win]) : 0;
                if (ok && rwe[win])
                    for (int k = 0; k < sz(rf3[win]); k++) ref_mem[ra[win]+k] = rd[win][8*k +: 8];
                r = (owner == win) ? run + 1 : 1;
                if (rlk[win] && r < MB) begin owner = win; run = r; end
                else begin owner = -1; run = 0; end
                last = win;
                pend[win] = 0;
            end else if (owner >= 0) begin
                last = owner; owner = -1; run = 0;
            end
            for (int p = 0; p < 2; p++) begin
                erv[p] = nrv[p]; eerr[p] = nerr[p]; erd[p] = nrd[p];
            end
            clk_step;
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_lock_burst;
        test_errors;
        test_reset_inflight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
